dac_spi_serializer: RTL
=======================

Name: dac_spi_serializer

Overview:
Downstream stage of the DDS signal generator control block. It takes the 12-bit unsigned waveform sample, latches it at a fixed frame rate and shifts it MSB-first into an external 12-bit serial DAC. Each frame is 16 bits: 4 control bits followed by 12 data bits, using SPI mode 0 (CPOL=0, CPHA=0) with active-low chip select. It also exposes the latched sample and a frame-done strobe for the monitor path.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (SCLK = clk / (2*CLK_DIV)); legal range ≥1.
FRAME_PERIOD, 100, clk cycles between frame starts (500 kSPS at 50 MHz); must be ≥ 33*CLK_DIV+2.
CTRL_BITS, 4'b0000, fixed DAC command nibble sent ahead of the data.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
enable  input  1  high = start new frames; low = finish the current frame, then idle
sample_in  input  12  unsigned sample from upstream (wave_out); max upstream value 3825
dac_cs_n  output  1  DAC chip select, active low
dac_sclk  output  1  DAC serial clock, idle low
dac_din  output  1  DAC serial data
busy  output  1  high while a frame is in progress (dac_cs_n low or trailing)
frame_done  output  1  one-clk pulse at frame end
sample_latched  output  12  sample captured for the current/last frame

Behaviour:
- Reset (async, immediate, including mid-frame):
  - dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, sample_latched=0.
  - Period counter = 0, state = IDLE.
- Period counter:
  - Free-runs 0..FRAME_PERIOD-1 and wraps, independent of state and enable.
  - Trigger occurs when the counter is FRAME_PERIOD-1.
- States: IDLE, SHIFT, TRAIL.
- IDLE, at trigger with enable=1:
  - On that edge: shreg <= {CTRL_BITS, sample_in}; sample_latched <= sample_in.
  - Also: dac_cs_n <= 0; dac_din <= CTRL_BITS[3]; busy <= 1; half-period counter and bit counter cleared.
  - Next state SHIFT.
  - Trigger with enable=0: no effect.
- SHIFT:
  - Half-period counter runs 0..CLK_DIV-1; dac_sclk toggles when it reaches CLK_DIV-1.
  - Rising SCLK: the DAC samples; dac_din is held stable.
  - Falling SCLK: shreg shifts left, dac_din <= next bit, bit counter increments.
  - After the 16th falling edge, go to TRAIL; dac_din <= 0.
  - Data is stable ≥ CLK_DIV clks either side of every rising edge.
- TRAIL:
  - Held for CLK_DIV clks, dac_sclk=0.
  - Then: dac_cs_n <= 1, busy <= 0, frame_done pulses 1 clk; next state IDLE.
- Frame timing: dac_cs_n low exactly 33*CLK_DIV clks (66 with defaults); 16 rising SCLK edges per frame.
- Upstream sample changes mid-frame have no effect on the frame in progress; only the value at the trigger edge is sent.
- enable deasserted mid-frame: the frame completes normally; no further frames start.
- A trigger arriving while not IDLE is ignored. This is unreachable under the FRAME_PERIOD constraint but is defined behaviour.
- Trigger-to-first-rising-SCLK latency: CLK_DIV clks after dac_cs_n falls.

Decomposition:
- Shared package holds:
  - FRAME_BITS=16, DATA_BITS=12, CTRL_W=4.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, TRAIL=2'd2.
  - Mode-0 SPI constants.
- One sub-module: dac_sclk_div. It is the half-period counter producing rise_en/fall_en one-clk enables; cleared on frame start.
- The serializer FSM, shift register and period counter stay in the top module.

Test Plan:
- Defaults, enable=1, sample_in=12'hA5C held:
  - dac_din at the 16 rising edges = 0000_1010_0101_1100.
  - dac_cs_n low 66 clks; frame_done once per 100 clks; sample_latched=12'hA5C.
- sample_in changes 12'h123→12'hFFF two clks after the trigger: the frame carries 12'h123; the next frame carries 12'hFFF.
- enable dropped 10 clks into a frame: the frame completes with 16 SCLK rises and one frame_done; no further dac_cs_n activity while enable=0.
- rst_n asserted mid-SHIFT (bit 7):
  - Same cycle: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0.
  - After release: first frame starts at counter wrap (FRAME_PERIOD clks later).
- CLK_DIV=1, FRAME_PERIOD=35: dac_sclk=25 MHz; dac_cs_n low 33 clks; back-to-back frames with 2 idle clks; no dropped trigger.
- CTRL_BITS=4'b1001, sample_in=12'h000: the bitstream is 1001 followed by twelve zeros.

Source files
------------

// File: rtl/dac_spi_serializer_pkg.sv
// Shared constants and state encoding for the DAC SPI serializer.
// The link runs in SPI mode 0: SCLK idles low, data is sampled on the rising edge.
package dac_spi_serializer_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CTRL_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2
    } state_e;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample/control inputs and DAC pins of the serializer.
// The master side is the upstream plus the board; the slave side is the serializer.
interface dac_spi_serializer_if;
    import dac_spi_serializer_pkg::*;

    logic                 enable;
    logic [DATA_BITS-1:0] sample_in;
    logic                 dac_cs_n;
    logic                 dac_sclk;
    logic                 dac_din;
    logic                 busy;
    logic                 frame_done;
    logic [DATA_BITS-1:0] sample_latched;

    modport master (
        output enable, sample_in,
        input  dac_cs_n, dac_sclk, dac_din, busy, frame_done, sample_latched
    );

    modport slave (
        input  enable, sample_in,
        output dac_cs_n, dac_sclk, dac_din, busy, frame_done, sample_latched
    );

endinterface

// File: rtl/dac_spi_serializer_sclk_div.sv
// Half-period counter for SCLK. It issues a tick every CLK_DIV clocks while running,
// and when toggling is allowed it flips SCLK and flags the rising or falling edge.
module dac_sclk_div
    import dac_spi_serializer_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    input  logic toggle_i,
    output logic tick_o,
    output logic rise_en_o,
    output logic fall_en_o,
    output logic sclk_o
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sclk_q, sclk_d;
    logic          at_end;

    assign at_end    = (hcnt_q == HW'(CLK_DIV - 1));
    assign tick_o    = run_i & at_end;
    assign rise_en_o = tick_o & toggle_i & ~sclk_q;
    assign fall_en_o = tick_o & toggle_i &  sclk_q;
    assign sclk_o    = sclk_q;

    always_comb begin
        hcnt_d = hcnt_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            hcnt_d = '0;
            sclk_d = SCLK_IDLE;
        end else if (run_i) begin
            hcnt_d = at_end ? '0 : hcnt_q + HW'(1);
            if (at_end && toggle_i) sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            sclk_q <= SCLK_IDLE;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Latches the upstream sample once per frame period and shifts {CTRL_BITS, sample}
// MSB-first into a 12-bit serial DAC over SPI mode 0.
module dac_spi_serializer
    import dac_spi_serializer_pkg::*;
#(
    parameter int                CLK_DIV      = 2,
    parameter int                FRAME_PERIOD = 100,
    parameter logic [CTRL_W-1:0] CTRL_BITS    = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dac_spi_serializer_if.slave  bus
);

    localparam int PW = $clog2(FRAME_PERIOD);
    localparam int BW = $clog2(FRAME_BITS);

    state_e                state_q, state_d;
    logic [PW-1:0]         per_q, per_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_BITS-1:0]  latched_q, latched_d;

    logic trig, start, last_fall;
    logic tick, rise_en, fall_en, sclk;

    // Free-running frame timer; it keeps counting regardless of state or enable.
    assign trig  = (per_q == PW'(FRAME_PERIOD - 1));
    assign per_d = trig ? '0 : per_q + PW'(1);

    assign start     = (state_q == IDLE) && trig && bus.enable;
    assign last_fall = fall_en && (bitcnt_q == BW'(FRAME_BITS - 1));

    dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start),
        .run_i     (state_q != IDLE),
        .toggle_i  (state_q == SHIFT),
        .tick_o    (tick),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en),
        .sclk_o    (sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            per_q     <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cs_n_q    <= CS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            latched_q <= '0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            latched_q <= latched_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = TRAIL;
            TRAIL:   if (tick)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // dac_din is the shift register MSB: zero-fill drives it low once all 16 bits are out.
    always_comb begin
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        latched_d = latched_q;
        case (state_q)
            IDLE: if (start) begin
                shreg_d   = {CTRL_BITS, bus.sample_in};
                latched_d = bus.sample_in;
                cs_n_d    = CS_ACTIVE;
                busy_d    = 1'b1;
                bitcnt_d  = '0;
            end
            SHIFT: if (fall_en) begin
                shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
                bitcnt_d = bitcnt_q + BW'(1);
            end
            TRAIL: if (tick) begin
                cs_n_d = CS_IDLE;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.dac_cs_n       = cs_n_q;
    assign bus.dac_sclk       = sclk;
    assign bus.dac_din        = shreg_q[FRAME_BITS-1];
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.sample_latched = latched_q;

    // The DAC samples on the rising edge, so data must not move there.
    a_din_stable: assert property (@(posedge clk) disable iff (!rst_n)
        rise_en |-> (shreg_d == shreg_q));

endmodule
